// File: rtl/mem_request_initiator.sv
// mem_request_initiator: round-robin arbiter funnelling consumer LSU requests
// onto a single memory port. Optional wait timeout: MEM_REQUEST_INITIATOR_TIMEOUT_EN.
module mem_request_initiator #(
    parameter int ADDR_BITS      = 12,
    parameter int DATA_BITS      = 16,
    parameter int NUM_CONSUMERS  = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
    output logic                                     mem_read_valid,
    output logic [ADDR_BITS-1:0]                     mem_read_address,
    input  logic                                     mem_read_ready,
    input  logic [DATA_BITS-1:0]                     mem_read_data,
    output logic                                     mem_write_valid,
    output logic [ADDR_BITS-1:0]                     mem_write_address,
    output logic [DATA_BITS-1:0]                     mem_write_data,
    input  logic                                     mem_write_ready,
    output logic                                     busy,
    output logic                                     timeout_error
);

    localparam int IDW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    if (NUM_CONSUMERS < 2 || (NUM_CONSUMERS & (NUM_CONSUMERS - 1)) != 0 ||
        TIMEOUT_CYCLES < 1) begin : g_param_chk
        $error("mem_request_initiator: invalid parameters");
    end

    typedef enum logic [1:0] {
        IDLE,
        READ_WAIT,
        WRITE_WAIT,
        RELAY
    } state_t;

    state_t                                  state_q, state_d;
    logic [IDW-1:0]                          rr_q, rr_d;
    logic [IDW-1:0]                          id_q, id_d;
    logic                                    is_rd_q, is_rd_d;
    logic [NUM_CONSUMERS-1:0]                crr_q, crr_d;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] crd_q, crd_d;
    logic [NUM_CONSUMERS-1:0]                cwr_q, cwr_d;
    logic                                    mrv_q, mrv_d;
    logic [ADDR_BITS-1:0]                    mra_q, mra_d;
    logic                                    mwv_q, mwv_d;
    logic [ADDR_BITS-1:0]                    mwa_q, mwa_d;
    logic [DATA_BITS-1:0]                    mwd_q, mwd_d;
    logic                                    busy_q;

    logic                                    found;
    logic                                    gnt_rd;
    logic [IDW-1:0]                          gnt_id;
    logic [IDW-1:0]                          idx;

`ifdef MEM_REQUEST_INITIATOR_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_q, to_d;
    logic          tmo;
    assign tmo = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`endif

    // Round-robin scan: first requester at or after rr_q wins, read before write.
    always_comb begin
        found  = 1'b0;
        gnt_rd = 1'b0;
        gnt_id = '0;
        idx    = '0;
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
            idx = rr_q + IDW'(i);
            if (!found && (consumer_read_valid[idx] || consumer_write_valid[idx])) begin
                found  = 1'b1;
                gnt_id = idx;
                gnt_rd = consumer_read_valid[idx];
            end
        end
    end

    // Next-state and registered-output logic for the transaction FSM.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        is_rd_d = is_rd_q;
        crr_d   = crr_q;
        crd_d   = crd_q;
        cwr_d   = cwr_q;
        mrv_d   = mrv_q;
        mra_d   = mra_q;
        mwv_d   = mwv_q;
        mwa_d   = mwa_q;
        mwd_d   = mwd_q;
`ifdef MEM_REQUEST_INITIATOR_TIMEOUT_EN
        cnt_d   = '0;
        to_d    = to_q;
`endif
        unique case (state_q)
            IDLE: begin
                // a lingering acknowledge belongs to the previous access
                if (found && !mem_read_ready && !mem_write_ready) begin
                    id_d    = gnt_id;
                    is_rd_d = gnt_rd;
                    if (gnt_rd) begin
                        mrv_d   = 1'b1;
                        mra_d   = consumer_read_address[gnt_id];
                        state_d = READ_WAIT;
                    end else begin
                        mwv_d   = 1'b1;
                        mwa_d   = consumer_write_address[gnt_id];
                        mwd_d   = consumer_write_data[gnt_id];
                        state_d = WRITE_WAIT;
                    end
                end
            end
            READ_WAIT: begin
                if (mem_read_ready) begin
                    mrv_d        = 1'b0;
                    crd_d[id_q]  = mem_read_data;
                    crr_d[id_q]  = 1'b1;
                    state_d      = RELAY;
                end
`ifdef MEM_REQUEST_INITIATOR_TIMEOUT_EN
                else if (tmo) begin
                    mrv_d        = 1'b0;
                    crd_d[id_q]  = '0;
                    crr_d[id_q]  = 1'b1;
                    to_d         = 1'b1;
                    state_d      = RELAY;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            WRITE_WAIT: begin
                if (mem_write_ready) begin
                    mwv_d        = 1'b0;
                    cwr_d[id_q]  = 1'b1;
                    state_d      = RELAY;
                end
`ifdef MEM_REQUEST_INITIATOR_TIMEOUT_EN
                else if (tmo) begin
                    mwv_d        = 1'b0;
                    cwr_d[id_q]  = 1'b1;
                    to_d         = 1'b1;
                    state_d      = RELAY;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            RELAY: begin
                if (is_rd_q ? !consumer_read_valid[id_q] : !consumer_write_valid[id_q]) begin
                    crr_d   = '0;
                    cwr_d   = '0;
                    rr_d    = id_q + IDW'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            is_rd_q <= 1'b0;
            crr_q   <= '0;
            crd_q   <= '0;
            cwr_q   <= '0;
            mrv_q   <= 1'b0;
            mra_q   <= '0;
            mwv_q   <= 1'b0;
            mwa_q   <= '0;
            mwd_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            is_rd_q <= is_rd_d;
            crr_q   <= crr_d;
            crd_q   <= crd_d;
            cwr_q   <= cwr_d;
            mrv_q   <= mrv_d;
            mra_q   <= mra_d;
            mwv_q   <= mwv_d;
            mwa_q   <= mwa_d;
            mwd_q   <= mwd_d;
            busy_q  <= (state_d != IDLE);
        end
    end

`ifdef MEM_REQUEST_INITIATOR_TIMEOUT_EN
    // Wait-cycle counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end
    assign timeout_error = to_q;
`else
    assign timeout_error = 1'b0;
`endif

    assign consumer_read_ready  = crr_q;
    assign consumer_read_data   = crd_q;
    assign consumer_write_ready = cwr_q;
    assign mem_read_valid       = mrv_q;
    assign mem_read_address     = mra_q;
    assign mem_write_valid      = mwv_q;
    assign mem_write_address    = mwa_q;
    assign mem_write_data       = mwd_q;
    assign busy                 = busy_q;

endmodule

// File: tb/tb_mem_request_initiator.sv
// tb_mem_request_initiator: directed vectors plus hand sequences against a
// one-cycle registered memory model.
module tb_mem_request_initiator;

    localparam int AW = 12;
    localparam int DW = 16;
    localparam int NC = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NC-1:0]         crv, crr, cwv, cwr;
    logic [NC-1:0][AW-1:0] cra, cwa;
    logic [NC-1:0][DW-1:0] crd, cwd;
    logic                  mrv, mwv, mrr, mwr;
    logic [AW-1:0]         mra, mwa;
    logic [DW-1:0]         mrd, mwd;
    logic                  busy, toe;

    mem_request_initiator #(
        .ADDR_BITS(AW), .DATA_BITS(DW),
        .NUM_CONSUMERS(NC), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .consumer_read_valid(crv), .consumer_read_address(cra),
        .consumer_read_ready(crr), .consumer_read_data(crd),
        .consumer_write_valid(cwv), .consumer_write_address(cwa),
        .consumer_write_data(cwd), .consumer_write_ready(cwr),
        .mem_read_valid(mrv), .mem_read_address(mra),
        .mem_read_ready(mrr), .mem_read_data(mrd),
        .mem_write_valid(mwv), .mem_write_address(mwa),
        .mem_write_data(mwd), .mem_write_ready(mwr),
        .busy(busy), .timeout_error(toe)
    );

    // memory model: acknowledge one cycle after valid, optional stall / stale ack
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          rack_q, wack_q, stall, stale, pre_we;
    logic [DW-1:0] rdat_q, pre_d;
    logic [AW-1:0] pre_a;
    assign mrr = rack_q | stale;
    assign mwr = wack_q;
    assign mrd = rdat_q;

    always @(posedge clk) begin
        if (reset) begin
            rack_q <= 1'b0;
            wack_q <= 1'b0;
            rdat_q <= '0;
        end else begin
            rack_q <= mrv & ~rack_q & ~stall;
            rdat_q <= mem[mra];
            wack_q <= mwv & ~wack_q;
        end
        if (pre_we) mem[pre_a] <= pre_d;
        else if (!reset && mwv && !wack_q) mem[mwa] <= mwd;
    end

    int errs = 0;
    int checks = 0;
    int overlap = 0;
    int multi = 0;

    always @(negedge clk) if (mrv && mwv) overlap++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        pre_we = 1'b1;
        pre_a  = a;
        pre_d  = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    typedef struct {
        bit            wr;
        int            c;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vt[6];

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        if (v.wr) begin
            cwv[v.c] = 1'b1; cwa[v.c] = v.a; cwd[v.c] = v.d;
        end else begin
            crv[v.c] = 1'b1; cra[v.c] = v.a;
        end
        @(negedge clk);
        if (v.wr) begin
            chk("wr_valid", 32'(mwv), 1);
            chk("wr_addr", 32'(mwa), 32'(v.a));
            chk("wr_data", 32'(mwd), 32'(v.d));
        end else begin
            chk("rd_valid", 32'(mrv), 1);
            chk("rd_addr", 32'(mra), 32'(v.a));
        end
        chk("busy_hi", 32'(busy), 1);
        @(negedge clk);
        chk("early_ready", 32'(crr | cwr), 0);
        chk("valid_held", 32'(mrv | mwv), 1);
        @(negedge clk);
        if (v.wr) chk("wr_ready", 32'(cwr), 32'(1) << v.c);
        else begin
            chk("rd_ready", 32'(crr), 32'(1) << v.c);
            chk("rd_data", 32'(crd[v.c]), 32'(v.exp));
        end
        chk("mem_valid_drop", 32'({mrv, mwv}), 0);
        @(negedge clk);
        chk("ready_hold", 32'(crr | cwr), 32'(1) << v.c);
        crv[v.c] = 1'b0;
        cwv[v.c] = 1'b0;
        @(negedge clk);
        chk("ready_drop", 32'(crr | cwr), 0);
        chk("busy_lo", 32'(busy), 0);
        if (v.wr) chk("mem_content", 32'(mem[v.a]), 32'(v.d));
    endtask

    int            ord[$];
    logic [DW-1:0] exp_rd [NC];

    task automatic service(input int want, input int bound);
        ord.delete();
        for (int k = 0; k < bound && ord.size() < want; k++) begin
            @(negedge clk);
            if ($countones(crr) + $countones(cwr) > 1) multi++;
            for (int i = 0; i < NC; i++) begin
                if (crr[i] && crv[i]) begin
                    ord.push_back(i);
                    chk("svc_rdata", 32'(crd[i]), 32'(exp_rd[i]));
                    crv[i] = 1'b0;
                end
                if (cwr[i] && cwv[i]) begin
                    ord.push_back(NC + i);
                    cwv[i] = 1'b0;
                end
            end
        end
        chk("svc_count", ord.size(), want);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        crv = '0; cwv = '0; cra = '0; cwa = '0; cwd = '0;
        stall = 1'b0; stale = 1'b0;
        pre_we = 1'b0; pre_a = '0; pre_d = '0;

        preload(12'h010, 16'hBEEF);
        preload(12'hFFF, 16'h1234);
        preload(12'h000, 16'h0000);
        preload(12'h020, 16'h1111);
        preload(12'h030, 16'h2222);
        preload(12'h040, 16'h3333);
        preload(12'h050, 16'h4444);

        chk("rst_mem_valid", 32'({mrv, mwv}), 0);
        chk("rst_ready", 32'({crr, cwr}), 0);
        chk("rst_addr", 32'({mra, mwa}), 0);
        chk("rst_wdata", 32'(mwd), 0);
        chk("rst_rdata", 32'(crd == '0), 1);
        chk("rst_busy_to", 32'({busy, toe}), 0);
        reset = 1'b0;

        vt[0] = '{wr: 0, c: 2, a: 12'h010, d: 16'h0000, exp: 16'hBEEF};
        vt[1] = '{wr: 1, c: 1, a: 12'h123, d: 16'hA5A5, exp: 16'h0000};
        vt[2] = '{wr: 0, c: 1, a: 12'h123, d: 16'h0000, exp: 16'hA5A5};
        vt[3] = '{wr: 0, c: 3, a: 12'hFFF, d: 16'h0000, exp: 16'h1234};
        vt[4] = '{wr: 1, c: 0, a: 12'h000, d: 16'hFFFF, exp: 16'h0000};
        vt[5] = '{wr: 0, c: 0, a: 12'h000, d: 16'h0000, exp: 16'hFFFF};
        for (int i = 0; i < 6; i++) run_vec(vt[i]);
        chk("rdata_hold_c2", 32'(crd[2]), 32'hBEEF);

        // all four read at once from rr_ptr 0, then a wrapped second round
        do_reset();
        exp_rd[0] = 16'hBEEF; exp_rd[1] = 16'h1111;
        exp_rd[2] = 16'h2222; exp_rd[3] = 16'h3333;
        @(negedge clk);
        cra = {12'h040, 12'h030, 12'h020, 12'h010};
        crv = 4'hF;
        service(4, 60);
        for (int k = 0; k < 4; k++) chk("rr_order", ord[k], k);
        crv = 4'b1001;
        service(2, 30);
        chk("rr_wrap_first", ord[0], 0);
        chk("rr_wrap_second", ord[1], 3);

        // read and write from the same consumer
        exp_rd[0] = 16'h4444;
        cra[0] = 12'h050; cwa[0] = 12'h060; cwd[0] = 16'h5A5A;
        crv[0] = 1'b1; cwv[0] = 1'b1;
        service(2, 30);
        chk("rw_first_read", ord[0], 0);
        chk("rw_then_write", ord[1], NC);
        chk("rw_mem", 32'(mem[12'h060]), 32'h5A5A);

        // stale acknowledge blocks a new issue
        stale = 1'b1;
        cra[3] = 12'h010; crv[3] = 1'b1;
        repeat (3) @(negedge clk);
        chk("stale_block", 32'({mrv, busy}), 0);
        stale = 1'b0;
        exp_rd[3] = 16'hBEEF;
        service(1, 20);
        chk("stale_then_grant", ord[0], 3);

        // reset during READ_WAIT aborts the access
        stall = 1'b1;
        @(negedge clk);
        cra[1] = 12'h010; crv[1] = 1'b1;
        repeat (2) @(negedge clk);
        chk("pre_abort_wait", 32'({mrv, busy}), 32'b11);
        reset = 1'b1; crv[1] = 1'b0;
        @(negedge clk);
        chk("abort_outputs", 32'({mrv, mwv, crr, cwr, busy, toe}), 0);
        chk("abort_addr", 32'(mra), 0);
        reset = 1'b0; stall = 1'b0;
        begin
            logic [NC-1:0] seen;
            seen = '0;
            repeat (4) begin
                @(negedge clk);
                seen = seen | crr | cwr;
            end
            chk("abort_no_ready", 32'(seen), 0);
        end

        // memory never acknowledges
        stall = 1'b1;
        @(negedge clk);
        cra[2] = 12'h010; crv[2] = 1'b1;
`ifdef MEM_REQUEST_INITIATOR_TIMEOUT_EN
        repeat (8) @(negedge clk);
        chk("to_still_wait", 32'({mrv, toe}), 32'b10);
        @(negedge clk);
        chk("to_valid_drop", 32'(mrv), 0);
        chk("to_flag", 32'(toe), 1);
        chk("to_ready", 32'(crr), 32'b0100);
        chk("to_data_zero", 32'(crd[2]), 0);
        crv[2] = 1'b0;
        repeat (2) @(negedge clk);
        chk("to_sticky", 32'({toe, busy}), 32'b10);
        stall = 1'b0;
`else
        repeat (20) @(negedge clk);
        chk("nto_valid_held", 32'(mrv), 1);
        chk("nto_flag", 32'(toe), 0);
        chk("nto_no_ready", 32'(crr), 0);
        stall = 1'b0;
        exp_rd[2] = 16'hBEEF;
        service(1, 20);
`endif

        chk("no_overlap", overlap, 0);
        chk("one_ready_max", multi, 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/mem_request_initiator.md
MEM_REQUEST_INITIATOR -- requirements
Module: mem_request_initiator

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 12, memory address width.
REQ-002 SHALL have parameter DATA_BITS, default 16, memory data width.
REQ-003 SHALL have parameter NUM_CONSUMERS, default 4, number of requesting thread LSUs (>=2, power of two).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, wait-state limit (used only when the timeout macro is defined).
REQ-005 Ports, in order:
  clk  input  1  clock, all logic on rising edge;
  reset  input  1  reset, synchronous, active-high;
  consumer_read_valid  input  [NUM_CONSUMERS]  read request per consumer;
  consumer_read_address  input  [NUM_CONSUMERS][ADDR_BITS]  read address;
  consumer_read_ready  output  [NUM_CONSUMERS]  read complete, data valid;
  consumer_read_data  output  [NUM_CONSUMERS][DATA_BITS]  returned read data;
  consumer_write_valid  input  [NUM_CONSUMERS]  write request;
  consumer_write_address  input  [NUM_CONSUMERS][ADDR_BITS]  write address;
  consumer_write_data  input  [NUM_CONSUMERS][DATA_BITS]  write data;
  consumer_write_ready  output  [NUM_CONSUMERS]  write complete;
  mem_read_valid  output  1  memory read request;
  mem_read_address  output  ADDR_BITS  memory read address;
  mem_read_ready  input  1  memory read acknowledge;
  mem_read_data  input  DATA_BITS  memory read data, valid with mem_read_ready;
  mem_write_valid  output  1  memory write request;
  mem_write_address  output  ADDR_BITS  memory write address;
  mem_write_data  output  DATA_BITS  memory write data;
  mem_write_ready  input  1  memory write acknowledge;
  busy  output  1  high in any state other than IDLE;
  timeout_error  output  1  sticky timeout flag.

Function
REQ-006 All outputs SHALL be registered; states: IDLE, READ_WAIT, WRITE_WAIT, RELAY.
REQ-007 IDLE: round-robin scan starting at rr_ptr; first consumer with read_valid or write_valid wins; read beats write for the same consumer.
REQ-008 IDLE SHALL NOT issue while mem_read_ready or mem_write_ready is high (stale acknowledge from previous transaction).
REQ-009 On grant: latch consumer id, address, data; assert mem_read_valid (-> READ_WAIT) or mem_write_valid (-> WRITE_WAIT) on the next edge.
REQ-010 READ_WAIT/WRITE_WAIT: hold valid, address, data stable until the matching ready samples high; then deassert valid, capture mem_read_data (read), go RELAY.
REQ-011 RELAY: assert consumer_read_ready[id] with consumer_read_data[id], or consumer_write_ready[id]; hold until the consumer's corresponding valid samples low; then deassert ready, rr_ptr <= (id+1) mod NUM_CONSUMERS, go IDLE.
REQ-012 consumer_read_data[id] SHALL hold the captured value until that consumer's next read completes; non-granted consumers' ready outputs SHALL stay low.
REQ-013 Latency with a one-cycle registered memory: consumer valid sampled at edge N -> mem valid after N -> ready after N+1 -> consumer ready after edge N+2.
REQ-014 At most one memory transaction SHALL be outstanding; mem_read_valid and mem_write_valid SHALL never both be high.
REQ-015 Requests arriving or withdrawn while not granted SHALL have no effect; a granted request is completed even if its valid drops early.
REQ-016 rr_ptr SHALL wrap from NUM_CONSUMERS-1 to 0.

Reset
REQ-017 On reset: state IDLE, rr_ptr 0, all valid/ready outputs 0, all address/data outputs 0, busy 0, timeout_error 0.
REQ-018 Reset mid-transaction SHALL abort it on the same edge; no consumer ready is produced for the aborted request.

Configuration
REQ-019 Macro MEM_REQUEST_INITIATOR_TIMEOUT_EN: when defined, a wait-cycle counter runs in READ_WAIT/WRITE_WAIT; after TIMEOUT_CYCLES cycles without ready, deassert mem valid, set timeout_error (sticky until reset), go RELAY returning read data 0.
REQ-020 When undefined: wait states last indefinitely, no counter logic, timeout_error tied 0.

Verification
REQ-021 Consumer 2 reads addr 0x010 holding 0xBEEF -> mem_read_valid/address 0x010 one cycle after request; consumer_read_ready[2] with data 0xBEEF 3 edges after request.
REQ-022 Consumer 1 writes 0xA5A5 to 0x123 -> memory location 0x123 = 0xA5A5; consumer_write_ready[1] pulses until valid drops.
REQ-023 All 4 consumers read simultaneously, rr_ptr 0 -> service order 0,1,2,3; next round after rr_ptr wraps starts at 0.
REQ-024 Consumer 0 asserts read and write together -> read serviced first, write next grant cycle; valid signals never overlap.
REQ-025 Reset asserted during READ_WAIT -> next cycle all outputs 0, state IDLE, no consumer ready.
REQ-026 Macro defined, TIMEOUT_CYCLES=8, memory never acknowledges -> after 8 wait cycles mem_read_valid drops, timeout_error=1, consumer_read_ready high with data 0; macro undefined -> mem_read_valid stays high, timeout_error 0.
